// File: rtl/led_pkg.sv
// Shared types and defaults for the LED drive blocks.
package led_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_STEP  = 1;

    typedef enum logic [1:0] {OFF, STATIC, RAMP_UP, RAMP_DOWN} pwm_state_t;

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for a divided clock sampled in the system clock domain.
module tick_edge_detect (
    input  logic clk_in,
    input  logic reset,
    input  logic tick_in,
    output logic tick_rise
);
    logic r_tick_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_tick_q <= 1'b0;
        end else begin
            r_tick_q <= tick_in;
        end
    end

    assign tick_rise = tick_in & ~r_tick_q;

endmodule

// File: rtl/led_pwm_engine.sv
// Per-LED PWM engine: static or breathe brightness, advanced by rising edges of a divided clock.
// Define LED_PWM_GAMMA_EN to compare against a quadratic gamma curve of the level.
module led_pwm_engine
    import led_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned STEP  = DEFAULT_STEP
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sleep,
    input  logic             tick_in,
    input  logic             enable,
    input  logic             breathe,
    input  logic [WIDTH-1:0] duty,
    input  logic             duty_load,
    output logic             led_out,
    output logic             period_done,
    output logic [WIDTH-1:0] level_out
);
    typedef logic [WIDTH-1:0] lvl_t;
    typedef logic [WIDTH:0]   ext_t;

    localparam lvl_t CNT_LAST = ~lvl_t'(1);
    localparam lvl_t STEP_N   = lvl_t'(STEP);
    localparam ext_t STEP_W   = ext_t'(STEP);

    lvl_t       r_cnt;
    lvl_t       r_level;
    lvl_t       r_pending;
    lvl_t       r_level_out;
    pwm_state_t r_state;
    logic       r_led;
    logic       r_pd;

    logic       w_tick_rise;
    lvl_t       w_level_cmp;
    ext_t       w_up_sum;
    lvl_t       w_up_level;
    lvl_t       w_dn_level;
    lvl_t       w_wrap_level;
    pwm_state_t w_wrap_state;

    tick_edge_detect u_tick_edge_detect (
        .clk_in    (clk_in),
        .reset     (reset),
        .tick_in   (tick_in),
        .tick_rise (w_tick_rise)
    );

`ifdef LED_PWM_GAMMA_EN
    logic [2*WIDTH-1:0] w_sq;
    lvl_t               w_sq_unused_lo;

    assign w_sq = {{WIDTH{1'b0}}, r_level} * {{WIDTH{1'b0}}, r_level}
                + {{WIDTH{1'b0}}, r_level};
    assign {w_level_cmp, w_sq_unused_lo} = w_sq;
`else
    assign w_level_cmp = r_level;
`endif

    // Ramp arithmetic is done one bit wider so the level saturates instead of wrapping.
    assign w_up_sum   = {1'b0, r_level} + STEP_W;
    assign w_up_level = (w_up_sum > {1'b0, r_pending}) ? r_pending : w_up_sum[WIDTH-1:0];
    assign w_dn_level = ({1'b0, r_level} > STEP_W) ? (r_level - STEP_N) : '0;

    always_comb begin
        w_wrap_level = r_level;
        w_wrap_state = r_state;
        case (r_state)
            STATIC: begin
                if (breathe) begin
                    w_wrap_state = (r_level != '0) ? RAMP_DOWN : RAMP_UP;
                end else begin
                    w_wrap_level = r_pending;
                end
            end
            RAMP_UP: begin
                if (!breathe) begin
                    w_wrap_state = STATIC;
                    w_wrap_level = r_pending;
                end else begin
                    w_wrap_level = w_up_level;
                    if ((w_up_level == r_pending) && (r_pending != '0)) begin
                        w_wrap_state = RAMP_DOWN;
                    end
                end
            end
            RAMP_DOWN: begin
                if (!breathe) begin
                    w_wrap_state = STATIC;
                    w_wrap_level = r_pending;
                end else begin
                    w_wrap_level = w_dn_level;
                    if (w_dn_level == '0) begin
                        w_wrap_state = RAMP_UP;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_cnt       <= '0;
            r_level     <= '0;
            r_pending   <= '0;
            r_level_out <= '0;
            r_state     <= OFF;
            r_led       <= 1'b0;
            r_pd        <= 1'b0;
        end else begin
            // Pending is captured even while asleep; a wrap in this cycle still uses the old value.
            if (duty_load) begin
                r_pending <= duty;
            end
            r_level_out <= r_level;
            if (sleep) begin
                r_led <= 1'b0;
                r_pd  <= 1'b0;
            end else begin
                r_led <= enable & (r_cnt < w_level_cmp);
                r_pd  <= 1'b0;
                if (!enable) begin
                    r_state <= OFF;
                    r_cnt   <= '0;
                    r_level <= r_pending;
                end else begin
                    case (r_state)
                        OFF: begin
                            r_cnt   <= '0;
                            r_level <= r_pending;
                            r_state <= breathe ? RAMP_UP : STATIC;
                        end
                        default: begin
                            if (w_tick_rise) begin
                                if (r_cnt == CNT_LAST) begin
                                    r_cnt   <= '0;
                                    r_pd    <= 1'b1;
                                    r_level <= w_wrap_level;
                                    r_state <= w_wrap_state;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign led_out     = r_led;
    assign period_done = r_pd;
    assign level_out   = r_level_out;

endmodule

// File: tb/tb_led_pwm_engine.sv
// Self-checking bench for led_pwm_engine: duty vector table with a per-period scoreboard,
// plus directed glitch-free update, breathe, sleep and reset sequences.
module tb_led_pwm_engine;
    import led_pkg::*;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         reset;
    logic         sleep;
    logic         tick_in;
    logic         enable;
    logic         breathe;
    logic [W-1:0] duty;
    logic         duty_load;
    logic         led_out;
    logic         period_done;
    logic [W-1:0] level_out;

    int checks   = 0;
    int failures = 0;
    int tick_div = 2;
    bit tick_run = 1'b0;
    bit mon_en   = 1'b0;

    typedef struct {
        int exp_hi;
        int skip;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int duty;
        int div;
        int exp_hi;
    } vec_t;
    vec_t vecs[7];

    int         exp_lvl[9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
    pwm_state_t exp_st[9]  = '{RAMP_UP, RAMP_UP, RAMP_UP, RAMP_DOWN, RAMP_DOWN, RAMP_DOWN,
                               RAMP_DOWN, RAMP_UP, RAMP_UP};

    led_pwm_engine #(
        .WIDTH (W),
        .STEP  (1)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .sleep       (sleep),
        .tick_in     (tick_in),
        .enable      (enable),
        .breathe     (breathe),
        .duty        (duty),
        .duty_load   (duty_load),
        .led_out     (led_out),
        .period_done (period_done),
        .level_out   (level_out)
    );

    initial forever #5 clk_in = ~clk_in;

    function automatic int model_g(input int l);
`ifdef LED_PWM_GAMMA_EN
        return (l * l + l) >> W;
`else
        return l;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One-cycle-high tick every tick_div cycles.
    initial begin
        int ph;
        ph = 0;
        tick_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (tick_run) begin
                ph = (ph + 1 >= tick_div) ? 0 : ph + 1;
                tick_in = (ph == 0);
            end else begin
                ph = 0;
                tick_in = 1'b0;
            end
        end
    end

    // A window runs from the cycle after one period_done through the next period_done.
    initial begin
        int  hi;
        int  gap;
        bit  have_pd;
        sb_t e;
        hi = 0;
        gap = 0;
        have_pd = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!mon_en) begin
                hi = 0;
                gap = 0;
                have_pd = 1'b0;
            end else begin
                if (led_out) hi++;
                gap++;
                if (period_done) begin
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        if (e.skip > 0) begin
                            e.skip--;
                            sb_q.push_front(e);
                        end else if (have_pd) begin
                            check("period_high_cycles", hi, e.exp_hi * tick_div);
                            check("period_length", gap, 255 * tick_div);
                        end
                    end
                    have_pd = 1'b1;
                    hi = 0;
                    gap = 0;
                end
            end
        end
    end

    task automatic load_duty(input int d);
        duty = d[W-1:0];
        duty_load = 1'b1;
        @(negedge clk_in);
        duty_load = 1'b0;
    endtask

    task automatic wait_pd(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!period_done && n < budget);
        check({name, "_period_done"}, int'(period_done), 1);
    endtask

    task automatic wait_cnt(input int value, input int budget, input string name);
        int n;
        n = 0;
        while (int'(dut.r_cnt) != value && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check(name, int'(dut.r_cnt), value);
    endtask

    task automatic wait_sb_empty(input int budget, input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check({name, "_pending"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        int bad;
        int n;
        reset = 1'b1;
        sleep = 1'b0;
        enable = 1'b0;
        breathe = 1'b0;
        duty = '0;
        duty_load = 1'b0;

        vecs[0] = '{64, 10, model_g(64)};
        vecs[1] = '{0, 2, model_g(0)};
        vecs[2] = '{255, 2, model_g(255)};
        vecs[3] = '{128, 2, model_g(128)};
        vecs[4] = '{1, 2, model_g(1)};
        vecs[5] = '{254, 2, model_g(254)};
        vecs[6] = '{200, 2, model_g(200)};

        tick_div = 10;
        tick_run = 1'b1;
        repeat (3) @(negedge clk_in);
        check("reset_led_out", int'(led_out), 0);
        check("reset_period_done", int'(period_done), 0);
        check("reset_level_out", int'(level_out), 0);
        check("reset_cnt", int'(dut.r_cnt), 0);
        check("reset_state", int'(dut.r_state), int'(OFF));
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            enable = 1'b0;
            mon_en = 1'b0;
            repeat (2) @(negedge clk_in);
            tick_div = vecs[i].div;
            load_duty(vecs[i].duty);
            sb_q.push_back('{vecs[i].exp_hi, 1});
            breathe = 1'b0;
            enable = 1'b1;
            mon_en = 1'b1;
            wait_sb_empty(3 * 255 * vecs[i].div + 50, "static_vec");
        end

        // Duty 200 -> 20 loaded mid-period: the running period must finish at 200.
        wait_cnt(50, 600, "glitch_cnt50");
        sb_q.push_back('{model_g(200), 0});
        sb_q.push_back('{model_g(20), 0});
        load_duty(20);
        wait_pd(600, "glitch_wrap");
        check("glitch_level_at_wrap", int'(level_out), 200);
        @(negedge clk_in);
        check("glitch_level_after_wrap", int'(level_out), 20);
        wait_sb_empty(1200, "glitch_sb");

        // Breathe from level 0 up to a peak of 4 and back.
        mon_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        tick_div = 2;
        breathe = 1'b1;
        enable = 1'b1;
        @(negedge clk_in);
        load_duty(4);
        for (int i = 0; i < 9; i++) begin
            wait_pd(600, "breathe_wrap");
            @(negedge clk_in);
            check("breathe_level", int'(level_out), exp_lvl[i]);
            check("breathe_state", int'(dut.r_state), int'(exp_st[i]));
        end

        // Sleep at cnt=100 freezes the engine and forces the LED off.
        breathe = 1'b0;
        enable = 1'b0;
        @(negedge clk_in);
        load_duty(128);
        enable = 1'b1;
        wait_cnt(100, 600, "sleep_cnt100");
        sleep = 1'b1;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_in);
            if (led_out || period_done) bad++;
        end
        check("sleep_outputs_low", bad, 0);
        check("sleep_cnt_frozen", int'(dut.r_cnt), 100);
        check("sleep_level_held", int'(level_out), 128);
        sleep = 1'b0;
        n = 0;
        while (int'(dut.r_cnt) == 100 && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        check("sleep_resume_cnt", int'(dut.r_cnt), 101);
        @(negedge clk_in);
        check("sleep_resume_led", int'(led_out), (101 < model_g(128)) ? 1 : 0);

        // Reset mid-period clears every output on the next cycle.
        wait_cnt(100, 600, "reset_cnt100");
        reset = 1'b1;
        @(negedge clk_in);
        check("midreset_led_out", int'(led_out), 0);
        check("midreset_period_done", int'(period_done), 0);
        check("midreset_level_out", int'(level_out), 0);
        check("midreset_cnt", int'(dut.r_cnt), 0);
        reset = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk_in);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pwm_engine.md
Name: led_pwm_engine

Overview:
- Per-LED PWM brightness engine. It sits directly downstream of variable_clock_divider and consumes that block's clk_out as a tick.
- Runs entirely in the clk_in domain. Rising edges of the divided clock advance a PWM counter, so the divisor sets the PWM base rate.
- Supports static brightness and a "breathe" mode that ramps brightness up and down once per PWM period. Duty updates are glitch-free.

Parameters:
- WIDTH, 8: bit width of the counter, duty and level. Period is MAX = 2^WIDTH-1 ticks.
- STEP, 1: level increment/decrement applied per period in breathe mode.

Ports:
- clk_in  input  1  system clock (same clock that drives variable_clock_divider).
- reset  input  1  synchronous, active-high reset.
- sleep  input  1  global sleep; freezes the engine.
- tick_in  input  1  divided clock (clk_out of variable_clock_divider).
- enable  input  1  channel enable.
- breathe  input  1  0 = static, 1 = breathe mode.
- duty  input  WIDTH  requested brightness / breathe peak.
- duty_load  input  1  single-cycle pulse; captures duty into the pending register.
- led_out  output  1  PWM drive, registered.
- period_done  output  1  single-cycle pulse at counter wrap.
- level_out  output  WIDTH  brightness level currently applied.

Behaviour:
- Clock and reset: one clock, clk_in. reset is synchronous and active-high. On reset: cnt, level, pending, tick_q, led_out, period_done and level_out are all 0; state is OFF.
- Tick detection:
  - tick_q <= tick_in every cycle; tick_rise = tick_in & ~tick_q.
  - tick_in must have a high and a low phase of at least 1 clk_in cycle each.
  - If tick_in is stuck (constant 0 or 1), the engine makes no progress. This is legal; no error is flagged.
- Counter:
  - On tick_rise, cnt <= (cnt == MAX-1) ? 0 : cnt+1, so cnt ranges 0..MAX-1.
  - period_done = 1 for exactly the cycle after cnt is written back to 0.
- Output compare:
  - led_out <= enable & ~sleep & (cnt < g(level)), where g is the identity unless the optional feature is enabled.
  - Level 0 gives always off; level MAX gives always on.
  - Latency: led_out lags cnt/level by 1 cycle.
- Pending register:
  - duty_load sets pending <= duty.
  - duty_load in the same cycle as a wrap: the old pending is used for that wrap; the new value applies at the next wrap.
- State machine (states from the shared package):
  - OFF: entered when enable=0 (from any state, next cycle). cnt held at 0; level <= pending each cycle.
  - On enable=1, go to STATIC if breathe=0, else RAMP_UP.
  - STATIC: at each wrap, level <= pending. Mode input changes are evaluated only at wrap.
  - RAMP_UP: at each wrap, level <= min(level+STEP, pending). Go to RAMP_DOWN when the new level equals pending and pending > 0.
    - If pending == 0, level stays 0 and the state stays RAMP_UP.
    - If pending < level, level clamps to pending and the state goes to RAMP_DOWN.
  - RAMP_DOWN: at each wrap, level <= (level > STEP) ? level-STEP : 0. Go to RAMP_UP when the new level is 0.
  - Sums must be computed at WIDTH+1 bits. Level must never wrap.
  - breathe 1->0 at a wrap: go to STATIC and set level <= pending.
  - breathe 0->1 at a wrap: go to RAMP_DOWN if level > 0, else RAMP_UP.
- Sleep: while sleep=1, cnt, level and state are frozen; led_out=0; period_done=0; tick_q still tracks tick_in. On sleep deassertion, resume from the frozen counter value.
- reset asserted mid-period has priority over all other inputs.

Optional Feature:
- Macro: LED_PWM_GAMMA_EN.
- Defined: g(level) = (level*level + level) >> WIDTH, computed at 2*WIDTH bits. Gives g(0)=0 and g(MAX)=MAX (for WIDTH=8: g(128)=64, g(255)=255). level_out still reports the linear level.
- Undefined: g(level) = level, and no multiplier is built.

Decomposition:
- Shared package led_pkg contains:
  - typedef enum logic [1:0] {OFF, STATIC, RAMP_UP, RAMP_DOWN} pwm_state_t.
  - Default WIDTH and STEP constants.
- One sub-module, tick_edge_detect: holds tick_q and outputs tick_rise. It is reusable by other LED blocks that consume clk_out.

Test Plan:
- Static 25%: WIDTH=8, tick_rise every 10 clk_in cycles, duty=64 with duty_load, enable=1 -> led_out high for exactly 64 of every 255 ticks; period_done every 2550 cycles.
- Extremes: duty=0 -> led_out never high; duty=255 -> led_out continuously high across wrap.
- Glitch-free update: duty 200->20 loaded mid-period at cnt=50 -> current period keeps level 200; level_out becomes 20 in the cycle after period_done.
- Breathe: duty=4, STEP=1 -> level_out sequence per period 1,2,3,4,3,2,1,0,1,... with state RAMP_UP/RAMP_DOWN switching at 4 and 0.
- Sleep/reset: sleep=1 at cnt=100 for 500 cycles -> led_out=0 and cnt stays 100, then resumes at 101 on the next tick. reset at cnt=100 -> all outputs 0 the next cycle.
- Gamma (LED_PWM_GAMMA_EN defined): duty=128 -> led_out high 64 of 255 ticks; duty=255 -> always high.
